instruction_fetch: RTL and testbench

Instruction fetch stage feeding the instruction decoder: holds the PC, issues word fetches to instruction memory over a valid/ready request channel, and collects in-order responses into a small FIFO. The FIFO head is presented to decode as `if_instruction` with its PC under a valid/ready handshake. A redirect from execute flushes the FIFO, discards stale in-flight responses and restarts fetch at the new PC.

---
 rtl/instruction_fetch.sv | 145 ++++++++++++++
 tb/tb_instruction_fetch.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : instruction_fetch                                               |
// | Purpose  : PC generation, credit-limited imem fetch, in-order response     |
// |            FIFO feeding decode; redirect flushes and drops stale returns.  |
// | Options  : IFETCH_MISALIGN_EN - misaligned redirect pushes a marker entry  |
// |            and halts fetch until the next redirect.                        |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module instruction_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_instruction,
  output logic [31:0] if_pc,
  output logic        if_misaligned,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc
);

  localparam int c_ptr_w = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int c_cnt_w = $clog2(DEPTH) + 1;

  logic [31:0]        r_fetch_pc;
  logic [31:0]        r_tail_pc;
  logic [c_cnt_w-1:0] r_count;
  logic [c_cnt_w-1:0] r_outstanding;
  logic [c_cnt_w-1:0] r_drop;
  logic               r_halted;
  logic [c_ptr_w-1:0] r_rd_ptr;
  logic [c_ptr_w-1:0] r_wr_ptr;
  logic [31:0]        r_pc_mem   [DEPTH];
  logic [31:0]        r_data_mem [DEPTH];

  logic               w_req_fire;
  logic               w_resp_fire;
  logic               w_push;
  logic               w_pop;
  logic               w_misalign;
  logic [c_cnt_w-1:0] w_out_next;
  logic [31:0]        w_target;

  // Credits cover both buffered entries and in-flight requests, so a push never overflows.
  assign imem_req_valid = !r_halted && ((int'(r_count) + int'(r_outstanding)) < DEPTH);
  assign imem_req_addr  = r_fetch_pc;

  assign w_req_fire  = imem_req_valid && imem_req_ready;
  assign w_resp_fire = imem_resp_valid;
  assign w_push      = w_resp_fire && (r_drop == '0) && !redirect_valid;
  assign w_pop       = if_valid && if_ready && !redirect_valid;
  assign w_out_next  = r_outstanding + c_cnt_w'(w_req_fire) - c_cnt_w'(w_resp_fire);
  assign w_target    = {redirect_pc[31:2], 2'b00};

  assign if_valid       = (r_count != '0);
  assign if_instruction = r_data_mem[r_rd_ptr];
  assign if_pc          = r_pc_mem[r_rd_ptr];

`ifdef IFETCH_MISALIGN_EN
  logic [DEPTH-1:0] r_mis_mem;

  assign w_misalign    = redirect_valid && (redirect_pc[1:0] != 2'b00);
  assign if_misaligned = r_mis_mem[r_rd_ptr];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_mis_mem <= '0;
    end else if (w_misalign) begin
      r_mis_mem[0] <= 1'b1;
    end else if (w_push) begin
      r_mis_mem[r_wr_ptr] <= 1'b0;
    end
  end
`else
  logic w_unused;

  assign w_misalign    = 1'b0;
  assign if_misaligned = 1'b0;
  assign w_unused      = ^redirect_pc[1:0];
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_fetch_pc    <= RESET_PC;
      r_tail_pc     <= RESET_PC;
      r_count       <= '0;
      r_outstanding <= '0;
      r_drop        <= '0;
      r_halted      <= 1'b0;
      r_rd_ptr      <= '0;
      r_wr_ptr      <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_pc_mem[i]   <= '0;
        r_data_mem[i] <= '0;
      end
    end else begin
      r_outstanding <= w_out_next;
      if (redirect_valid) begin
        // Everything still in flight after this cycle belongs to the old stream.
        r_drop     <= w_out_next;
        r_fetch_pc <= w_target;
        r_tail_pc  <= w_target;
        r_rd_ptr   <= '0;
        if (w_misalign) begin
          r_pc_mem[0]   <= redirect_pc;
          r_data_mem[0] <= 32'h0000_0013;
          r_wr_ptr      <= c_ptr_w'(1);
          r_count       <= c_cnt_w'(1);
          r_halted      <= 1'b1;
        end else begin
          r_wr_ptr <= '0;
          r_count  <= '0;
          r_halted <= 1'b0;
        end
      end else begin
        if (w_req_fire) begin
          r_fetch_pc <= r_fetch_pc + 32'd4;
        end
        if (w_resp_fire && (r_drop != '0)) begin
          r_drop <= r_drop - c_cnt_w'(1);
        end
        if (w_push) begin
          r_pc_mem[r_wr_ptr]   <= r_tail_pc;
          r_data_mem[r_wr_ptr] <= imem_resp_data;
          r_wr_ptr             <= r_wr_ptr + c_ptr_w'(1);
          r_tail_pc            <= r_tail_pc + 32'd4;
        end
        if (w_pop) begin
          r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
        end
        r_count <= r_count + c_cnt_w'(w_push) - c_cnt_w'(w_pop);
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_instruction_fetch.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_instruction_fetch                                            |
// | Purpose  : vector table, directed corner sequences and random traffic      |
// |            against a queue-based model of the fetch stage.                 |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module tb_instruction_fetch;

  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid = 1'b0;
  logic [31:0] imem_resp_data = '0;
  logic        if_valid;
  logic        if_ready = 1'b0;
  logic [31:0] if_instruction;
  logic [31:0] if_pc;
  logic        if_misaligned;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;

  instruction_fetch #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset_n(reset_n),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
    .if_valid(if_valid), .if_ready(if_ready), .if_instruction(if_instruction),
    .if_pc(if_pc), .if_misaligned(if_misaligned),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] pc; logic [31:0] instr; logic mis; } entry_t;
  typedef struct { logic [31:0] data; int due; } resp_t;
  typedef struct {
    bit rdy; bit ifr; bit redir; logic [31:0] rpc;
    bit e_rv; logic [31:0] e_addr; bit e_iv; bit chk_head; logic [31:0] e_pc; logic [31:0] e_instr;
  } vec_t;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int lat_min = 1;
  int lat_max = 1;

  // Reference model: spec-level state with a queue standing in for the FIFO.
  entry_t      m_fifo[$];
  int          m_out, m_drop;
  logic [31:0] m_fetch, m_tail;
  bit          m_halted;
  resp_t       mem_q[$];
  logic [31:0] acc_q[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic bit m_req_valid();
    return !m_halted && ((m_fifo.size() + m_out) < DEPTH);
  endfunction

  task automatic model_reset();
    m_fifo.delete(); mem_q.delete(); acc_q.delete();
    m_out = 0; m_drop = 0; m_halted = 0; cyc = 0;
    m_fetch = RESET_PC; m_tail = RESET_PC;
  endtask

  task automatic model_check();
    chk("req_valid", imem_req_valid, m_req_valid());
    if (m_req_valid()) chk("req_addr", imem_req_addr, m_fetch);
    chk("if_valid", if_valid, m_fifo.size() != 0);
    if (m_fifo.size() != 0) begin
      chk("if_pc", if_pc, m_fifo[0].pc);
      chk("if_instruction", if_instruction, m_fifo[0].instr);
      chk("if_misaligned", if_misaligned, m_fifo[0].mis);
    end
  endtask

  task automatic model_step(input bit rf, input bit resp, input logic [31:0] d,
                            input bit ifr, input bit redir, input logic [31:0] rpc);
    bit pop;
    pop   = ifr && (m_fifo.size() != 0);
    m_out = m_out + int'(rf) - int'(resp);
    if (redir) begin
      m_fifo.delete();
      m_drop   = m_out;
      m_fetch  = rpc & 32'hFFFF_FFFC;
      m_tail   = m_fetch;
      m_halted = 0;
`ifdef IFETCH_MISALIGN_EN
      if (rpc[1:0] != 2'b00) begin
        m_fifo.push_back('{rpc, 32'h0000_0013, 1'b1});
        m_halted = 1;
      end
`endif
    end else begin
      if (rf) m_fetch = m_fetch + 32'd4;
      if (pop) void'(m_fifo.pop_front());
      if (resp) begin
        if (m_drop > 0) m_drop--;
        else begin
          m_fifo.push_back('{m_tail, d, 1'b0});
          m_tail = m_tail + 32'd4;
        end
      end
    end
  endtask

  // One clock: check outputs, drive inputs, advance memory and model across the edge.
  task automatic cycle(input bit rdy, input bit ifr, input bit redir, input logic [31:0] rpc);
    bit rv, mrv, qv;
    logic [31:0] rd, qa;
    model_check();
    rv = (mem_q.size() != 0) && (mem_q[0].due <= cyc);
    rd = rv ? mem_q[0].data : $urandom;
    imem_req_ready = rdy; imem_resp_valid = rv; imem_resp_data = rd;
    if_ready = ifr; redirect_valid = redir; redirect_pc = rpc;
    mrv = m_req_valid();
    #3;
    qv = imem_req_valid && rdy;
    qa = imem_req_addr;
    @(posedge clk);
    if (rv) void'(mem_q.pop_front());
    if (qv) begin
      mem_q.push_back('{qa ^ 32'hA5A5_0000, cyc + int'($urandom_range(lat_max, lat_min))});
      acc_q.push_back(qa);
    end
    model_step(mrv && rdy, rv, rd, ifr, redir, rpc);
    cyc++;
    #1;
  endtask

  task automatic hold_reset();
    reset_n = 1'b0;
    imem_req_ready = 0; imem_resp_valid = 0; if_ready = 0; redirect_valid = 0; redirect_pc = '0;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    model_reset();
  endtask

  vec_t vt[6];

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int n0;
    logic [31:0] rpc;
    vt[0] = '{1, 1, 0, 32'h0, 1, 32'h0000_0000, 0, 1, 32'h0, 32'h0};
    vt[1] = '{1, 1, 0, 32'h0, 1, 32'h0000_0004, 0, 0, 32'h0, 32'h0};
    vt[2] = '{1, 1, 0, 32'h0, 1, 32'h0000_0008, 1, 1, 32'h0000_0000, 32'hA5A5_0000};
    vt[3] = '{1, 1, 0, 32'h0, 1, 32'h0000_000C, 1, 1, 32'h0000_0004, 32'hA5A5_0004};
    vt[4] = '{1, 1, 0, 32'h0, 1, 32'h0000_0010, 1, 1, 32'h0000_0008, 32'hA5A5_0008};
    vt[5] = '{1, 1, 0, 32'h0, 1, 32'h0000_0014, 1, 1, 32'h0000_000C, 32'hA5A5_000C};

    // Zero-wait streaming from reset, checked against fixed vectors.
    lat_min = 1; lat_max = 1;
    hold_reset();
    for (int i = 0; i < 6; i++) begin
      chk("tbl_req_valid", imem_req_valid, vt[i].e_rv);
      chk("tbl_req_addr", imem_req_addr, vt[i].e_addr);
      chk("tbl_if_valid", if_valid, vt[i].e_iv);
      if (vt[i].chk_head) begin
        chk("tbl_if_pc", if_pc, vt[i].e_pc);
        chk("tbl_if_instruction", if_instruction, vt[i].e_instr);
        chk("tbl_if_misaligned", if_misaligned, 1'b0);
      end
      cycle(vt[i].rdy, vt[i].ifr, vt[i].redir, vt[i].rpc);
    end

    // Decode stalled: credits cap issue at DEPTH, then resume at 0x10.
    hold_reset();
    for (int i = 0; i < 8; i++) cycle(1, 0, 0, 0);
    chk("stall_req_count", acc_q.size(), 4);
    chk("stall_req_valid", imem_req_valid, 1'b0);
    for (int i = 0; i < 8; i++) cycle(1, 1, 0, 0);
    chk("resume_addr", (acc_q.size() > 4) ? acc_q[4] : 32'hDEAD_BEEF, 32'h0000_0010);

    // Latency 3, three in flight, redirect: stale returns dropped.
    lat_min = 3; lat_max = 3;
    hold_reset();
    for (int i = 0; i < 3; i++) cycle(1, 1, 0, 0);
    chk("lat_issued", acc_q.size(), 3);
    cycle(0, 1, 1, 32'h0000_0100);
    chk("lat_redir_empty", if_valid, 1'b0);
    chk("lat_redir_addr", imem_req_addr, 32'h0000_0100);
    for (int i = 0; i < 30 && !if_valid; i++) cycle(1, 0, 0, 0);
    chk("lat_first_pc", if_valid ? if_pc : 32'hDEAD_BEEF, 32'h0000_0100);
    chk("lat_first_instr", if_instruction, 32'hA5A5_0100);

    // Redirect coinciding with a pop and a response.
    lat_min = 1; lat_max = 1;
    hold_reset();
    for (int i = 0; i < 5; i++) cycle(1, 1, 0, 0);
    chk("pre_redir_if_valid", if_valid, 1'b1);
    cycle(1, 1, 1, 32'h0000_0040);
    chk("post_redir_empty", if_valid, 1'b0);
    chk("post_redir_addr", imem_req_addr, 32'h0000_0040);
    for (int i = 0; i < 6; i++) cycle(1, 1, 0, 0);

    // Misaligned redirect target.
    hold_reset();
    for (int i = 0; i < 2; i++) cycle(1, 1, 0, 0);
    cycle(1, 0, 1, 32'h0000_0102);
`ifdef IFETCH_MISALIGN_EN
    chk("mis_if_valid", if_valid, 1'b1);
    chk("mis_flag", if_misaligned, 1'b1);
    chk("mis_pc", if_pc, 32'h0000_0102);
    chk("mis_instr", if_instruction, 32'h0000_0013);
    chk("mis_halt_req", imem_req_valid, 1'b0);
    n0 = acc_q.size();
    for (int i = 0; i < 6; i++) cycle(1, 1, 0, 0);
    chk("mis_halt_no_req", acc_q.size() - n0, 0);
    cycle(1, 1, 1, 32'h0000_0200);
    chk("mis_resume_valid", imem_req_valid, 1'b1);
    chk("mis_resume_addr", imem_req_addr, 32'h0000_0200);
`else
    chk("mis_if_valid", if_valid, 1'b0);
    chk("mis_req_valid", imem_req_valid, 1'b1);
    chk("mis_aligned_addr", imem_req_addr, 32'h0000_0100);
`endif
    for (int i = 0; i < 8; i++) cycle(1, 1, 0, 0);

    // Address wrap at 2^32.
    cycle(1, 1, 1, 32'hFFFF_FFF8);
    for (int i = 0; i < 8; i++) cycle(1, 1, 0, 0);

    // Asynchronous reset with two entries buffered.
    hold_reset();
    for (int i = 0; i < 3; i++) cycle(1, 0, 0, 0);
    chk("rst_pre_if_valid", if_valid, 1'b1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("rst_if_valid", if_valid, 1'b0);
    chk("rst_if_pc", if_pc, 32'h0);
    chk("rst_if_instruction", if_instruction, 32'h0);
    chk("rst_if_misaligned", if_misaligned, 1'b0);
    chk("rst_req_valid", imem_req_valid, 1'b1);
    chk("rst_req_addr", imem_req_addr, RESET_PC);
    hold_reset();
    for (int i = 0; i < 4; i++) cycle(1, 1, 0, 0);
    chk("rst_first_req", (acc_q.size() > 0) ? acc_q[0] : 32'hDEAD_BEEF, RESET_PC);

    // Random traffic against the model.
    lat_min = 1; lat_max = 4;
    hold_reset();
    for (int i = 0; i < 600; i++) begin
      rpc = ($urandom & 32'h0000_0FFC) | ((($urandom % 4) == 0) ? ($urandom % 4) : 32'h0);
      cycle(($urandom % 4) != 0, ($urandom % 3) != 0, ($urandom % 25) == 0, rpc);
    end
    model_check();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
